// File: rtl/uart_host_pkg.sv
// Shared definitions for the host-side UART blocks (transmitter now,
// receiver later): frame geometry, default timing and FSM state encodings.
package uart_host_pkg;

  // Payload bits per 8N1 frame.
  localparam int DATA_BITS = 8;

  // 16x oversample * divider 27 -> 115200 bps at the model's system clock.
  localparam int DEFAULT_BIT_CYCLES = 432;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // 2-bit frame FSM encoding shared by TX and the future RX.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Width needed to hold a count from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_host_fifo.sv
// Synchronous byte FIFO feeding the host UART transmitter.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wr_data write request and data (ignored while full)
//   pop           read request (ignored while empty)
//   rd_data       head entry, valid whenever empty==0
//   full, empty   decoded from the registered occupancy count
module uart_host_fifo
  import uart_host_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = DATA_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // A push while full is refused even if a pop frees a slot this cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is read combinationally: the consumer captures it into its own
  // register on the pop edge, so no extra read latency is introduced.
  assign rd_data = mem[rd_ptr_reg];

  // Storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: drives the SoC RxD pin with 8N1 frames
// (LSB first) taken from an internal byte FIFO, honouring SoC hold between
// frames.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   wr_data, wr_en   byte push into the FIFO (dropped while full)
//   hold             1 = do not start a new frame (checked only in IDLE)
//   ovf_clr          clears the sticky overflow flag
//   txd              registered serial output, idle high
//   full, empty      FIFO status
//   busy             frame in progress
//   tx_done          one-cycle pulse aligned with the last stop-bit cycle
//   overflow         sticky: push attempted while full
module uart_host_tx
  import uart_host_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       hold,
  input  logic       ovf_clr,
  output logic       txd,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx_done,
  output logic       overflow
);

  localparam logic [15:0] CYC_LAST = 16'(BIT_CYCLES - 1);
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_t   state_reg, state_next;
  logic [15:0] cyc_reg, cyc_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        txd_reg, txd_next;
  logic        done_reg, done_next;
  logic        overflow_reg;
  logic        pop;
  logic [7:0]  head_data;
  logic        bit_end;

  uart_host_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head_data),
    .full    (full),
    .empty   (empty)
  );

  assign bit_end = (cyc_reg == CYC_LAST);

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    txd_next   = 1'b1;
    done_next  = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty && !hold) begin
          pop        = 1'b1;
          shift_next = head_data;
          cyc_next   = '0;
          bit_next   = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        txd_next = 1'b0;
        if (bit_end) begin
          cyc_next   = '0;
          state_next = ST_DATA;
        end else begin
          cyc_next = cyc_reg + 16'd1;
        end
      end
      ST_DATA: begin
        txd_next = shift_reg[0];
        if (bit_end) begin
          cyc_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == BIT_LAST) begin
            bit_next   = '0;
            state_next = ST_STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          cyc_next = cyc_reg + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          // Registered alongside txd, so the pulse lines up with the
          // final stop-bit cycle seen on the line.
          done_next  = 1'b1;
          cyc_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cyc_next = cyc_reg + 16'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // txd is a register driven from the current state, so the line lags the
  // FSM by one clock; this keeps the pin glitch-free and puts the falling
  // start edge two clocks after the byte lands in an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cyc_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
      done_reg  <= done_next;
    end
  end

  // A new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (wr_en && full) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign txd      = txd_reg;
  assign tx_done  = done_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_host_tx.sv
module tb_uart_host_tx;

  logic       clk;
  logic       rst;

  logic [7:0] wr_data;
  logic       wr_en;
  logic       hold;
  logic       ovf_clr;
  logic       txd, full, empty, busy, tx_done, overflow;

  logic [7:0] wr_data2;
  logic       wr_en2;
  logic       hold2;
  logic       ovf_clr2;
  logic       txd2, full2, empty2, busy2, tx_done2, overflow2;

  int n_cmp;
  int n_err;

  uart_host_tx #(.BIT_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .hold     (hold),
    .ovf_clr  (ovf_clr),
    .txd      (txd),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .tx_done  (tx_done),
    .overflow (overflow)
  );

  uart_host_tx #(.BIT_CYCLES(4), .FIFO_DEPTH(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data2),
    .wr_en    (wr_en2),
    .hold     (hold2),
    .ovf_clr  (ovf_clr2),
    .txd      (txd2),
    .full     (full2),
    .empty    (empty2),
    .busy     (busy2),
    .tx_done  (tx_done2),
    .overflow (overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic txd_of(input int sel);
    return (sel != 0) ? txd2 : txd;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel != 0) ? tx_done2 : tx_done;
  endfunction

  // Called at a negedge; the byte is taken at the following posedge and
  // the task returns at the negedge after it.
  task automatic push(input int sel, input logic [7:0] b);
    if (sel != 0) begin
      wr_data2 = b;
      wr_en2   = 1'b1;
    end else begin
      wr_data = b;
      wr_en   = 1'b1;
    end
    @(negedge clk);
    wr_en  = 1'b0;
    wr_en2 = 1'b0;
  endtask

  // Waits for the start bit then checks all 40 line cycles of the frame
  // plus the tx_done pulse position. exp_wait < 0 disables the latency
  // check; hold_at >= 0 raises hold on that line cycle.
  task automatic check_frame(input string name, input int sel, input logic [7:0] exp_byte,
                             input int exp_wait, input int hold_at);
    logic [9:0] frame;
    int w;
    int bad;
    frame = {1'b1, exp_byte, 1'b0};
    w = 0;
    while (txd_of(sel) !== 1'b0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (txd_of(sel) !== 1'b0) begin
      n_err++;
      $display("FAIL %s start_bit: txd=%b after %0d clk, required 0", name, txd_of(sel), w);
      return;
    end
    if (exp_wait >= 0) begin
      n_cmp++;
      if (w != exp_wait) begin
        n_err++;
        $display("FAIL %s start_latency: %0d clk, required %0d", name, w, exp_wait);
      end
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == hold_at) hold = 1'b1;
      n_cmp++;
      if (txd_of(sel) !== frame[i/4]) begin
        n_err++;
        bad++;
        $display("FAIL %s txd[%0d]: got %b, required %b", name, i, txd_of(sel), frame[i/4]);
      end
      n_cmp++;
      if (done_of(sel) !== (i == 39)) begin
        n_err++;
        bad++;
        $display("FAIL %s tx_done[%0d]: got %b, required %b", name, i, done_of(sel), (i == 39));
      end
      @(negedge clk);
    end
    $display("frame %s byte=0x%02h wait=%0d errors=%0d", name, exp_byte, w, bad);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({txd, full, empty, busy, tx_done, overflow} !== 6'b101000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required 101000",
               {txd, full, empty, busy, tx_done, overflow});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({txd, full, empty, busy, tx_done, overflow} !== 6'b101000) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b, required 101000",
               {txd, full, empty, busy, tx_done, overflow});
    end
    $display("reset checked");
  endtask

  task automatic test_single_a5();
    push(0, 8'hA5);
    n_cmp++;
    if (empty !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) begin
      n_err++;
      $display("FAIL a5_after_push: empty=%b busy=%b txd=%b, required 0 0 1", empty, busy, txd);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || empty !== 1'b1 || txd !== 1'b1) begin
      n_err++;
      $display("FAIL a5_after_pop: busy=%b empty=%b txd=%b, required 1 1 1", busy, empty, txd);
    end
    check_frame("a5", 0, 8'hA5, 1, -1);
    n_cmp++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      n_err++;
      $display("FAIL a5_idle_after: busy=%b txd=%b, required 0 1", busy, txd);
    end
  endtask

  task automatic test_back_to_back();
    push(0, 8'h55);
    push(0, 8'hAA);
    push(0, 8'h0F);
    check_frame("b2b_55", 0, 8'h55, 0, -1);
    check_frame("b2b_aa", 0, 8'hAA, 1, -1);
    check_frame("b2b_0f", 0, 8'h0F, 1, -1);
    n_cmp++;
    if (empty !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drained: empty=%b busy=%b, required 1 0", empty, busy);
    end
  endtask

  task automatic test_overflow();
    int lows;
    hold = 1'b1;
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    n_cmp++;
    if (full !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_three_not_full: full=%b, required 0", full);
    end
    push(0, 8'h04);
    n_cmp++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_four_full: full=%b overflow=%b, required 1 0", full, overflow);
    end
    push(0, 8'h05);
    n_cmp++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_fifth_dropped: overflow=%b full=%b, required 1 1", overflow, full);
    end
    // clear and a new overflow in the same cycle: flag must remain set
    ovf_clr = 1'b1;
    push(0, 8'h06);
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_clr_vs_set: overflow=%b, required 1", overflow);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
    end
    hold = 1'b0;
    check_frame("ovf_01", 0, 8'h01, 2, -1);
    check_frame("ovf_02", 0, 8'h02, 1, -1);
    check_frame("ovf_03", 0, 8'h03, 1, -1);
    check_frame("ovf_04", 0, 8'h04, 1, -1);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      if (txd !== 1'b1) lows++;
      @(negedge clk);
    end
    n_cmp++;
    if (lows != 0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_only_four: extra low cycles=%0d empty=%b, required 0 1", lows, empty);
    end
  endtask

  task automatic test_hold_mid();
    int lows;
    hold = 1'b0;
    push(0, 8'h3C);
    push(0, 8'h99);
    check_frame("hold_3c", 0, 8'h3C, 1, 16);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1) lows++;
      @(negedge clk);
    end
    n_cmp++;
    if (lows != 0 || busy !== 1'b0 || empty !== 1'b0) begin
      n_err++;
      $display("FAIL hold_blocks_start: low cycles=%0d busy=%b empty=%b, required 0 0 0",
               lows, busy, empty);
    end
    hold = 1'b0;
    check_frame("hold_99", 0, 8'h99, 2, -1);
  endtask

  task automatic test_reset_mid();
    push(0, 8'hFF);
    push(0, 8'h77);
    repeat (18) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_in_frame: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (txd !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abort: txd=%b busy=%b empty=%b full=%b tx_done=%b, required 1 0 1 0 0",
               txd, busy, empty, full, tx_done);
    end
    @(negedge clk);
    rst = 1'b0;
    push(0, 8'h01);
    check_frame("rstmid_01", 0, 8'h01, 2, -1);
  endtask

  task automatic test_fifo2_push_pop();
    hold2 = 1'b1;
    push(1, 8'h11);
    hold2 = 1'b0;
    push(1, 8'h22);
    n_cmp++;
    if (empty2 !== 1'b0 || full2 !== 1'b0 || busy2 !== 1'b1) begin
      n_err++;
      $display("FAIL d2_push_pop_count: empty=%b full=%b busy=%b, required 0 0 1",
               empty2, full2, busy2);
    end
    check_frame("d2_11", 1, 8'h11, 1, -1);
    check_frame("d2_22", 1, 8'h22, 1, -1);
    n_cmp++;
    if (empty2 !== 1'b1) begin
      n_err++;
      $display("FAIL d2_drained: empty=%b, required 1", empty2);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    wr_data  = 8'h00;
    wr_en    = 1'b0;
    hold     = 1'b0;
    ovf_clr  = 1'b0;
    wr_data2 = 8'h00;
    wr_en2   = 1'b0;
    hold2    = 1'b0;
    ovf_clr2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_overflow();
    test_hold_mid();
    test_reset_mid();
    test_fifo2_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
